// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle for apb_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface apb_master_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  PCLKEN;
  logic [1:0]            REQ;
  logic [ADDR_WIDTH-1:0] REQ_ADDR0;
  logic [ADDR_WIDTH-1:0] REQ_ADDR1;
  logic [1:0]            REQ_WRITE;
  logic [31:0]           REQ_WDATA0;
  logic [31:0]           REQ_WDATA1;
  logic [3:0]            REQ_STRB0;
  logic [3:0]            REQ_STRB1;
  logic [2:0]            REQ_PROT0;
  logic [2:0]            REQ_PROT1;
  logic [1:0]            DONE;
  logic [31:0]           RDATA0;
  logic [31:0]           RDATA1;
  logic [1:0]            ERR;
  logic [1:0]            GRANT;
  logic                  TIMEOUT_EV;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  logic                  APBACTIVE;

  modport master (
    input  PCLKEN, REQ, REQ_ADDR0, REQ_ADDR1, REQ_WRITE, REQ_WDATA0, REQ_WDATA1,
           REQ_STRB0, REQ_STRB1, REQ_PROT0, REQ_PROT1, PRDATA, PREADY, PSLVERR,
    output DONE, RDATA0, RDATA1, ERR, GRANT, TIMEOUT_EV, PADDR, PSEL, PENABLE,
           PWRITE, PWDATA, PSTRB, PPROT, APBACTIVE
  );

  modport slave (
    output PCLKEN, REQ, REQ_ADDR0, REQ_ADDR1, REQ_WRITE, REQ_WDATA0, REQ_WDATA1,
           REQ_STRB0, REQ_STRB1, REQ_PROT0, REQ_PROT1, PRDATA, PREADY, PSLVERR,
    input  DONE, RDATA0, RDATA1, ERR, GRANT, TIMEOUT_EV, PADDR, PSEL, PENABLE,
           PWRITE, PWDATA, PSTRB, PPROT, APBACTIVE
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: PCLKEN-qualified SETUP/ACCESS sequencing,
// per-requester read data / error return, and an ACCESS-phase watchdog.
module apb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  apb_master_arbiter_if.master bus
);
  localparam bit                   WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = WD_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            done_q, done_d;
  logic                  tev_q, tev_d;
  logic [1:0]            err_q, err_d;
  logic [31:0]           rdata0_q, rdata0_d;
  logic [31:0]           rdata1_q, rdata1_d;
  logic                  load, win, fin, fin_err;
  logic [31:0]           fin_rdata;

  logic [ADDR_WIDTH-1:0] paddr_q, sel_addr;
  logic                  pwrite_q, sel_write;
  logic [31:0]           pwdata_q, sel_wdata;
  logic [3:0]            pstrb_q, sel_strb;
  logic [2:0]            pprot_q, sel_prot;
  logic                  psel_q, penable_q;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    done_d    = 2'b00;
    tev_d     = 1'b0;
    err_d     = err_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    load      = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = 32'h0;
    // On a tie the requester that did not win last time goes next.
    win       = (bus.REQ == 2'b11) ? ~last_q : bus.REQ[1];
    unique case (state_q)
      IDLE: begin
        if (bus.PCLKEN && (bus.REQ != 2'b00)) begin
          state_d = SETUP;
          load    = 1'b1;
          last_d  = win;
          grant_d = win ? 2'b10 : 2'b01;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (bus.PCLKEN) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (bus.PCLKEN) begin
          if (bus.PREADY) begin
            fin       = 1'b1;
            fin_err   = bus.PSLVERR;
            fin_rdata = bus.PRDATA;
          end else if (WD_EN && (cnt_q == CNT_LAST)) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            tev_d   = 1'b1;
          end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d              = IDLE;
      grant_d              = 2'b00;
      done_d               = grant_q;
      err_d[grant_q[1]]    = fin_err;
      if (!pwrite_q) begin
        if (grant_q[1]) rdata1_d = fin_rdata;
        else            rdata0_d = fin_rdata;
      end
    end
  end

  // Winner's payload, strobes suppressed for reads.
  always_comb begin
    sel_addr  = win ? bus.REQ_ADDR1  : bus.REQ_ADDR0;
    sel_write = bus.REQ_WRITE[win];
    sel_wdata = win ? bus.REQ_WDATA1 : bus.REQ_WDATA0;
    sel_prot  = win ? bus.REQ_PROT1  : bus.REQ_PROT0;
    sel_strb  = sel_write ? (win ? bus.REQ_STRB1 : bus.REQ_STRB0) : 4'h0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q     <= '0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      tev_q     <= 1'b0;
      err_q     <= 2'b00;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'h0;
      pstrb_q   <= 4'h0;
      pprot_q   <= 3'h0;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      tev_q     <= tev_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      if (load) begin
        paddr_q  <= sel_addr;
        pwrite_q <= sel_write;
        pwdata_q <= sel_wdata;
        pstrb_q  <= sel_strb;
        pprot_q  <= sel_prot;
      end
    end
  end

  assign bus.DONE       = done_q;
  assign bus.RDATA0     = rdata0_q;
  assign bus.RDATA1     = rdata1_q;
  assign bus.ERR        = err_q;
  assign bus.GRANT      = grant_q;
  assign bus.TIMEOUT_EV = tev_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.PSTRB      = pstrb_q;
  assign bus.PPROT      = pprot_q;
  assign bus.APBACTIVE  = (state_q != IDLE) | (|bus.REQ);
endmodule
